jtcps2_obj_draw: RTL and testbench



---
 rtl/jtcps2_obj_draw_pkg.sv | 21 ++
 rtl/jtcps2_obj_draw_if.sv | 30 +++
 rtl/jtcps2_obj_draw_pxl.sv | 43 ++++
 rtl/jtcps2_obj_draw.sv | 171 +++++++++++++++++
 tb/tb_jtcps2_obj_draw.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/jtcps2_obj_draw_pkg.sv
// Shared definitions for the CPS2 object tile renderer: FSM states,
// transparent colour default, dr_attr field positions and ROM address width.
package jtcps2_obj_draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH0 = 2'd1,
        ST_DRAW0  = 2'd2,
        ST_DRAW1  = 2'd3
    } state_t;

    localparam logic [3:0] TRANSP_DEF = 4'hF;

    localparam int VSUB_MSB  = 11;
    localparam int VSUB_LSB  = 8;
    localparam int HFLIP_BIT = 5;
    localparam int PAL_MSB   = 4;

    localparam int ROM_AW = 20;

endpackage

// File: rtl/jtcps2_obj_draw_if.sv
// Scanner handshake, object ROM port and line-buffer write port of the renderer.
interface jtcps2_obj_draw_if;
    import jtcps2_obj_draw_pkg::*;

    logic              dr_start;
    logic              dr_idle;
    logic [15:0]       dr_code;
    logic [15:0]       dr_attr;
    logic [8:0]        dr_hpos;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_half;
    logic              rom_cs;
    logic              rom_ok;
    logic [31:0]       rom_data;
    logic [8:0]        buf_addr;
    logic [8:0]        buf_data;
    logic              buf_wr;

    // slave: the renderer; master: scanner + ROM + line buffer environment
    modport slave (
        input  dr_start, dr_code, dr_attr, dr_hpos, rom_ok, rom_data,
        output dr_idle, rom_addr, rom_half, rom_cs, buf_addr, buf_data, buf_wr
    );

    modport master (
        output dr_start, dr_code, dr_attr, dr_hpos, rom_ok, rom_data,
        input  dr_idle, rom_addr, rom_half, rom_cs, buf_addr, buf_data, buf_wr
    );

endinterface

// File: rtl/jtcps2_obj_draw_pxl.sv
// Planar pixel shifter: holds one 32-bit ROM word and emits one 4bpp colour
// per shift, leftmost-first or (hflip) rightmost-first.
module jtcps2_obj_draw_pxl (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic        hflip,
    input  logic [31:0] din,
    output logic [3:0]  colour
);

    logic [31:0] word_q;
    logic [31:0] word_d;
    logic [31:0] shifted;

    // Each byte is one bit plane; byte 3 supplies the colour MSB.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_plane
            assign colour[gi] = hflip ? word_q[gi*8] : word_q[gi*8+7];
            assign shifted[gi*8 +: 8] = hflip ? {1'b0, word_q[gi*8+1 +: 7]}
                                              : {word_q[gi*8 +: 7], 1'b0};
        end
    endgenerate

    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = din;
        end else if (shift) begin
            word_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/jtcps2_obj_draw.sv
// CPS2 object tile renderer: fetches two planar ROM words per 16-pixel tile row
// and writes the opaque pixels into the object line buffer.
module jtcps2_obj_draw
    import jtcps2_obj_draw_pkg::*;
#(
    parameter logic [3:0] TRANSP = TRANSP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    jtcps2_obj_draw_if.slave bus
);

    state_t            state_q, state_d;
    logic              hflip_q, hflip_d;
    logic [PAL_MSB:0]  pal_q, pal_d;
    logic [8:0]        hpos_q, hpos_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              rom_half_q, rom_half_d;
    logic              rom_cs_q, rom_cs_d;
    logic              idle_q, idle_d;
    logic              wait_q, wait_d;
    logic              have1_q, have1_d;
    logic [31:0]       word1_q, word1_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              stall_q, stall_d;

    logic              accept, ready1, draw_en;
    logic              pxl_load, pxl_shift;
    logic [31:0]       pxl_din;
    logic [3:0]        colour;
    logic [8:0]        offs;
    logic              unused_attr;

    assign unused_attr = ^{bus.dr_attr[15:VSUB_MSB+1], bus.dr_attr[VSUB_LSB-1:HFLIP_BIT+1]};

    // rom_ok is only trusted once the address has been stable for a full cycle
    assign accept = rom_cs_q & bus.rom_ok & ~wait_q;
    assign ready1 = have1_q | accept;
    assign offs   = {5'd0, state_q == ST_DRAW1, cnt_q};

    jtcps2_obj_draw_pxl u_pxl (
        .clk    (clk),
        .rst    (rst),
        .load   (pxl_load),
        .shift  (pxl_shift),
        .hflip  (hflip_q),
        .din    (pxl_din),
        .colour (colour)
    );

    always_comb begin
        state_d    = state_q;
        hflip_d    = hflip_q;
        pal_d      = pal_q;
        hpos_d     = hpos_q;
        rom_addr_d = rom_addr_q;
        rom_half_d = rom_half_q;
        rom_cs_d   = rom_cs_q;
        idle_d     = idle_q;
        wait_d     = 1'b0;
        have1_d    = have1_q;
        word1_d    = word1_q;
        cnt_d      = cnt_q;
        stall_d    = stall_q;
        pxl_load   = 1'b0;
        pxl_shift  = 1'b0;
        pxl_din    = bus.rom_data;
        draw_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.dr_start) begin
                    hflip_d    = bus.dr_attr[HFLIP_BIT];
                    pal_d      = bus.dr_attr[PAL_MSB:0];
                    hpos_d     = bus.dr_hpos;
                    rom_addr_d = {bus.dr_code, bus.dr_attr[VSUB_MSB:VSUB_LSB]};
                    rom_half_d = bus.dr_attr[HFLIP_BIT];
                    rom_cs_d   = 1'b1;
                    idle_d     = 1'b0;
                    wait_d     = 1'b1;
                    have1_d    = 1'b0;
                    stall_d    = 1'b0;
                    cnt_d      = 3'd0;
                    state_d    = ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                if (accept) begin
                    pxl_load   = 1'b1;
                    rom_half_d = ~hflip_q;
                    wait_d     = 1'b1;
                    state_d    = ST_DRAW0;
                end
            end
            ST_DRAW0: begin
                if (accept) begin
                    word1_d  = bus.rom_data;
                    have1_d  = 1'b1;
                    rom_cs_d = 1'b0;
                end
                draw_en   = ~stall_q;
                pxl_shift = ~stall_q;
                if (!stall_q) begin
                    cnt_d = cnt_q + 3'd1;
                end
                if (stall_q || cnt_q == 3'd7) begin
                    if (ready1) begin
                        pxl_load = 1'b1;
                        pxl_din  = have1_q ? word1_q : bus.rom_data;
                        cnt_d    = 3'd0;
                        stall_d  = 1'b0;
                        state_d  = ST_DRAW1;
                    end else begin
                        stall_d  = 1'b1;
                    end
                end
            end
            ST_DRAW1: begin
                draw_en   = 1'b1;
                pxl_shift = 1'b1;
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    idle_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hflip_q    <= 1'b0;
            pal_q      <= '0;
            hpos_q     <= '0;
            rom_addr_q <= '0;
            rom_half_q <= 1'b0;
            rom_cs_q   <= 1'b0;
            idle_q     <= 1'b1;
            wait_q     <= 1'b0;
            have1_q    <= 1'b0;
            word1_q    <= '0;
            cnt_q      <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hflip_q    <= hflip_d;
            pal_q      <= pal_d;
            hpos_q     <= hpos_d;
            rom_addr_q <= rom_addr_d;
            rom_half_q <= rom_half_d;
            rom_cs_q   <= rom_cs_d;
            idle_q     <= idle_d;
            wait_q     <= wait_d;
            have1_q    <= have1_d;
            word1_q    <= word1_d;
            cnt_q      <= cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.dr_idle  = idle_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_half = rom_half_q;
    assign bus.rom_cs   = rom_cs_q;
    assign bus.buf_wr   = draw_en & (colour != TRANSP);
    assign bus.buf_addr = draw_en ? hpos_q + offs : 9'd0;
    assign bus.buf_data = draw_en ? {pal_q, colour} : 9'd0;

endmodule

// File: tb/tb_jtcps2_obj_draw.sv
// Scoreboard bench for jtcps2_obj_draw: expected line-buffer writes are queued
// per tile and checked by an independent monitor on every buf_wr.
module tb_jtcps2_obj_draw;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtcps2_obj_draw_if bus();

    jtcps2_obj_draw #(.TRANSP(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM model: half 0 returns w_left, half 1 returns w_right
    logic [31:0] w_left, w_right;
    logic        rom_ok_en;
    assign bus.rom_data = bus.rom_half ? w_right : w_left;
    assign bus.rom_ok   = rom_ok_en;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [8:0] addr;
        logic [8:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.buf_wr === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h (no write required)",
                         cyc, bus.buf_addr, bus.buf_data);
            end else begin
                e = exp_q.pop_front();
                if (e.cycle != cyc || e.addr !== bus.buf_addr || e.data !== bus.buf_data) begin
                    fails++;
                    $display("FAIL buf_write got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                             cyc, bus.buf_addr, bus.buf_data, e.cycle, e.addr, e.data);
                end else begin
                    $display("[TB] write cyc=%0d addr=%0d data=%h ok", cyc, bus.buf_addr, bus.buf_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %h required %h", name, act, req);
        end else begin
            $display("[TB] %s = %h ok", name, act);
        end
    endtask

    function automatic logic [3:0] pix(input logic [31:0] w, input int p);
        return {w[31-p], w[23-p], w[15-p], w[7-p]};
    endfunction

    // Queue the writes a tile should produce; writes at or after abort_cyc are dropped.
    task automatic push_tile(input int s, input logic [8:0] hpos, input logic hf,
                             input logic [4:0] pal, input int stall_extra, input int abort_cyc);
        wr_t        e;
        logic [31:0] w;
        logic [3:0]  c;
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 8; k++) begin
                w = ((h == 0) ^ hf) ? w_left : w_right;
                c = pix(w, hf ? 7 - k : k);
                e.cycle = s + 2 + h*8 + k + ((h == 1) ? stall_extra : 0);
                e.addr  = hpos + 9'(h*8 + k);
                e.data  = {pal, c};
                if (c != 4'hF && e.cycle < abort_cyc) exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_tile(input logic [15:0] code, input logic [3:0] vsub, input logic hf,
                              input logic [4:0] pal, input logic [8:0] hpos,
                              input int stall_extra, input int abort_after, output int s);
        s = cyc + 1;
        push_tile(s, hpos, hf, pal, stall_extra, s + abort_after);
        bus.dr_code  = code;
        bus.dr_attr  = {4'h0, vsub, 2'b00, hf, pal};
        bus.dr_hpos  = hpos;
        bus.dr_start = 1'b1;
        @(negedge clk);
        bus.dr_start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string name, input int req_cyc);
        int n = 0;
        while (bus.dr_idle !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(cyc), 32'(req_cyc));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int s;
        rst = 1'b1;
        rom_ok_en = 1'b1;
        w_left = '0;
        w_right = '0;
        bus.dr_start = 1'b0;
        bus.dr_code = '0;
        bus.dr_attr = '0;
        bus.dr_hpos = '0;
        repeat (3) @(negedge clk);

        check("rst_dr_idle",  32'(bus.dr_idle),  32'd1);
        check("rst_rom_cs",   32'(bus.rom_cs),   32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_rom_half", 32'(bus.rom_half), 32'd0);
        check("rst_buf_wr",   32'(bus.buf_wr),   32'd0);
        check("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        check("rst_buf_data", 32'(bus.buf_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic tile, no flip
        w_left  = 32'h3C5A_96E1;
        w_right = 32'h0F1E_2D4B;
        start_tile(16'h1234, 4'h5, 1'b0, 5'h0A, 9'd100, 0, 100, s);
        check("basic_rom_addr", 32'(bus.rom_addr), 32'h12345);
        check("basic_rom_half0", 32'(bus.rom_half), 32'd0);
        check("basic_rom_cs", 32'(bus.rom_cs), 32'd1);
        check("basic_busy", 32'(bus.dr_idle), 32'd0);
        wait_cyc(s + 2);
        check("basic_rom_half1", 32'(bus.rom_half), 32'd1);
        wait_idle("basic_idle_cyc", s + 18);

        // hflip, started back-to-back; word0 (half 1) unpacks reversed to 5,5,5,5,A,A,A,A
        w_left  = 32'h0000_0000;
        w_right = 32'hF00F_F00F;
        start_tile(16'h0ABC, 4'h3, 1'b1, 5'h1F, 9'd100, 0, 100, s);
        check("hflip_rom_addr", 32'(bus.rom_addr), 32'h0ABC3);
        check("hflip_rom_half0", 32'(bus.rom_half), 32'd1);
        wait_cyc(s + 2);
        check("hflip_rom_half1", 32'(bus.rom_half), 32'd0);
        wait_idle("hflip_idle_cyc", s + 18);

        // Fully transparent tile
        w_left  = 32'hFFFF_FFFF;
        w_right = 32'hFFFF_FFFF;
        start_tile(16'h7777, 4'hA, 1'b0, 5'h05, 9'd40, 0, 100, s);
        wait_idle("transp_idle_cyc", s + 18);

        // Wrap at 512 with a 5-cycle stall waiting for word 1
        w_left  = 32'h1248_8421;
        w_right = 32'hA5C3_5A3C;
        start_tile(16'hBEEF, 4'hC, 1'b0, 5'h11, 9'd508, 5, 100, s);
        wait_cyc(s + 2);
        rom_ok_en = 1'b0;
        wait_cyc(s + 12);
        check("stall_buf_wr", 32'(bus.buf_wr), 32'd0);
        wait_cyc(s + 14);
        rom_ok_en = 1'b1;
        wait_idle("stall_idle_cyc", s + 23);

        // dr_start while busy is ignored
        w_left  = 32'h6E6E_0101;
        w_right = 32'h9191_FE10;
        start_tile(16'h5555, 4'h1, 1'b0, 5'h03, 9'd200, 0, 100, s);
        wait_cyc(s + 3);
        bus.dr_code  = 16'hAAAA;
        bus.dr_attr  = {4'h0, 4'hE, 2'b00, 1'b1, 5'h1C};
        bus.dr_hpos  = 9'd0;
        bus.dr_start = 1'b1;
        @(negedge clk);
        bus.dr_start = 1'b0;
        check("ignore_rom_addr", 32'(bus.rom_addr), 32'h55551);
        check("ignore_rom_half", 32'(bus.rom_half), 32'd1);
        wait_idle("ignore_idle_cyc", s + 18);

        // Reset mid-tile aborts immediately, then a fresh tile runs normally
        w_left  = 32'h0123_4567;
        w_right = 32'h89AB_CDE0;
        start_tile(16'h4321, 4'h2, 1'b0, 5'h08, 9'd300, 0, 5, s);
        wait_cyc(s + 4);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rom_cs", 32'(bus.rom_cs), 32'd0);
        check("abort_buf_wr", 32'(bus.buf_wr), 32'd0);
        check("abort_dr_idle", 32'(bus.dr_idle), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        start_tile(16'h2468, 4'h9, 1'b0, 5'h12, 9'd10, 0, 100, s);
        check("after_rst_rom_addr", 32'(bus.rom_addr), 32'h24689);
        wait_idle("after_rst_idle_cyc", s + 18);

        repeat (4) @(negedge clk);
        check("missing_writes", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
